// File: rtl/cmp_8bit_serial_msb.sv
// Bit-serial MSB-first magnitude comparator.
// Captures an operand pair through a valid/ready handshake and walks the
// bits from the top down, one bit per clock, stopping at the first bit where
// the operands differ. The result is presented as one-hot lt/eq/gt together
// with the number of bits that had to be examined.
module cmp_8bit_serial_msb #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       x,
    input  logic [WIDTH-1:0]       y,
    input  logic                   is_signed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   lt,
    output logic                   eq,
    output logic                   gt,
    output logic [$clog2(WIDTH):0] scan_len
);

    localparam int IW = $clog2(WIDTH);
    localparam int LW = IW + 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        RST_WAIT,
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic             sgn;
    logic [IW-1:0]    idx;

    logic bit_x;
    logic bit_y;
    logic differ;
    logic at_msb;
    logic at_lsb;

    // Handshake flags are pure decodes of the state register, so no input
    // ever reaches them combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Bit currently under inspection and where it sits in the word.
    always_comb begin
        bit_x  = xs[idx];
        bit_y  = ys[idx];
        differ = bit_x ^ bit_y;
        at_msb = (idx == IDX_TOP);
        at_lsb = (idx == '0);
    end

    // State register; reset parks the block in RST_WAIT so in_ready only
    // rises one edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: scan ends on the first differing bit or after the LSB.
    always_comb begin
        next_state = state;
        case (state)
            RST_WAIT: next_state = IDLE;
            IDLE: begin
                if (in_valid) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (differ || at_lsb) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = RST_WAIT;
        endcase
    end

    // Operand capture, bit walk and result registers. In signed mode only
    // the sign bit has inverted meaning: a 1 there marks the smaller value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs       <= '0;
            ys       <= '0;
            sgn      <= 1'b0;
            idx      <= '0;
            lt       <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            scan_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xs       <= x;
                        ys       <= y;
                        sgn      <= is_signed;
                        idx      <= IDX_TOP;
                        scan_len <= '0;
                    end
                end
                SCAN: begin
                    scan_len <= scan_len + LW'(1);
                    if (differ) begin
                        if (at_msb && sgn) begin
                            lt <= bit_x;
                            gt <= bit_y;
                        end else begin
                            gt <= bit_x;
                            lt <= bit_y;
                        end
                    end else if (at_lsb) begin
                        eq <= 1'b1;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        lt       <= 1'b0;
                        eq       <= 1'b0;
                        gt       <= 1'b0;
                        scan_len <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
